// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port among load, ALU and MDU
// requesters, with anti-starvation promotion of MDU/ALU behind a busy load stream.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ld_valid,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_mdu_valid,
    input  logic [4:0]  i_mdu_rd,
    input  logic [31:0] i_mdu_data,
    output logic        o_mdu_ready,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic [1:0]  o_wb_src
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_LD   = 2'b01,
        SRC_ALU  = 2'b10,
        SRC_MDU  = 2'b11
    } src_e;

    logic [CNT_W-1:0]  r_mdu_cnt;
    logic [CNT_W-1:0]  r_alu_cnt;
    logic              r_wren;
    logic [RD_W-1:0]   r_addr;
    logic [DATA_W-1:0] r_data;
    src_e              r_src;

    logic              w_mdu_starved;
    logic              w_alu_starved;
    src_e              w_grant;
    logic [RD_W-1:0]   w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;

    assign w_mdu_starved = (r_mdu_cnt == LIMIT);
    assign w_alu_starved = (r_alu_cnt == LIMIT);

    // Starved requesters jump ahead of load; otherwise load > MDU > ALU.
    always_comb begin
        w_grant = SRC_NONE;
        if (!i_reset) begin
            if (i_mdu_valid && w_mdu_starved)      w_grant = SRC_MDU;
            else if (i_alu_valid && w_alu_starved) w_grant = SRC_ALU;
            else if (i_ld_valid)                   w_grant = SRC_LD;
            else if (i_mdu_valid)                  w_grant = SRC_MDU;
            else if (i_alu_valid)                  w_grant = SRC_ALU;
        end
    end

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        case (w_grant)
            SRC_LD:  begin w_sel_rd = i_ld_rd;  w_sel_data = i_ld_data;  end
            SRC_ALU: begin w_sel_rd = i_alu_rd; w_sel_data = i_alu_data; end
            SRC_MDU: begin w_sel_rd = i_mdu_rd; w_sel_data = i_mdu_data; end
            default: begin w_sel_rd = '0;       w_sel_data = '0;         end
        endcase
    end

    assign o_ld_ready  = (w_grant == SRC_LD);
    assign o_alu_ready = (w_grant == SRC_ALU);
    assign o_mdu_ready = (w_grant == SRC_MDU);

    // Saturating wait counter: counts denied-while-valid cycles, clears otherwise.
    function automatic logic [CNT_W-1:0] next_cnt(input logic valid, input logic granted,
                                                  input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        nxt = '0;
        if (valid && !granted) nxt = (cnt >= LIMIT) ? LIMIT : cnt + CNT_W'(1);
        return nxt;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mdu_cnt <= '0;
            r_alu_cnt <= '0;
            r_wren    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_src     <= SRC_NONE;
        end else begin
            r_mdu_cnt <= next_cnt(i_mdu_valid, w_grant == SRC_MDU, r_mdu_cnt);
            r_alu_cnt <= next_cnt(i_alu_valid, w_grant == SRC_ALU, r_alu_cnt);
            // Writes to x0 are accepted but dropped from the write port.
            if (w_grant != SRC_NONE && w_sel_rd != '0) begin
                r_wren <= 1'b1;
                r_addr <= w_sel_rd;
                r_data <= w_sel_data;
                r_src  <= w_grant;
            end else begin
                r_wren <= 1'b0;
                r_addr <= '0;
                r_data <= '0;
                r_src  <= SRC_NONE;
            end
        end
    end

    assign o_rd_wren = r_wren;
    assign o_rd_addr = r_addr;
    assign o_rd_data = r_data;
    assign o_wb_src  = r_src;
endmodule
